// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl: host-side start/end-of-conversion controller for the RSA engine.
// Issues a one-cycle start_cmd on an accepted go, captures the engine result at
// end of conversion and holds done until acknowledged. A watchdog and a host
// abort terminate a run early with a one-cycle stop_cmd.
module rsa_cmd_ctrl #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned TIMEOUT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 go,
   input  logic                 abort,
   input  logic                 ack,
   input  logic [TIMEOUT_W-1:0] timeout_val,
   input  logic                 eocp,
   input  logic                 eoc,
   input  logic [WIDTH-1:0]     result_in,
   output logic                 start_cmd,
   output logic                 stop_cmd,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_flag,
   output logic [WIDTH-1:0]     result_out
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_START   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_STOP    = 3'd5;

   logic [2:0]           state_q;
   logic [2:0]           state_d;
   logic [TIMEOUT_W-1:0] cnt_q;
   logic [TIMEOUT_W-1:0] cnt_d;
   logic                 start_d;
   logic                 stop_d;
   logic                 busy_d;
   logic                 done_d;
   logic                 tflag_d;
   logic [WIDTH-1:0]     result_d;

   logic                 wd_en;
   logic                 cnt_one;
   logic                 cnt_gt_one;
   logic                 cnt_nz;
   logic [TIMEOUT_W-1:0] cnt_dec;

   // Watchdog helpers: a zero load value disables expiry and counting.
   always_comb begin
      wd_en      = (timeout_val != '0);
      cnt_one    = (cnt_q == TIMEOUT_W'(1));
      cnt_gt_one = (cnt_q >  TIMEOUT_W'(1));
      cnt_nz     = (cnt_q != '0);
      cnt_dec    = cnt_q - TIMEOUT_W'(1);
   end

   // Next-state and next-output logic; pulse outputs default low, the rest hold.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      busy_d   = busy;
      done_d   = done;
      tflag_d  = timeout_flag;
      result_d = result_out;

      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_START;
               cnt_d   = timeout_val;
               done_d  = 1'b0;
               tflag_d = 1'b0;
               busy_d  = 1'b1;
               start_d = 1'b1;
            end
         end

         S_START: begin
            // The START cycle counts toward the watchdog so expiry lands T
            // edges after the accepted go; never count below 1 here.
            state_d = S_WAIT;
            if (wd_en && cnt_gt_one) begin
               cnt_d = cnt_dec;
            end
         end

         S_WAIT: begin
            if (abort) begin
               state_d = S_STOP;
               stop_d  = 1'b1;
               tflag_d = 1'b0;
            end else if (eocp) begin
               state_d = S_CAPTURE;
            end else if (wd_en && cnt_one) begin
               state_d = S_STOP;
               stop_d  = 1'b1;
               tflag_d = 1'b1;
            end else if (wd_en && cnt_nz) begin
               cnt_d = cnt_dec;
            end
         end

         S_CAPTURE: begin
            if (abort) begin
               state_d = S_STOP;
               stop_d  = 1'b1;
               tflag_d = 1'b0;
            end else if (eoc) begin
               state_d  = S_DONE;
               result_d = result_in;
               done_d   = 1'b1;
               busy_d   = 1'b0;
            end else if (wd_en && cnt_one) begin
               state_d = S_STOP;
               stop_d  = 1'b1;
               tflag_d = 1'b1;
            end else if (wd_en && cnt_nz) begin
               cnt_d = cnt_dec;
            end
         end

         S_DONE: begin
            // A new go wins over ack and relaunches straight from DONE.
            if (go) begin
               state_d = S_START;
               cnt_d   = timeout_val;
               done_d  = 1'b0;
               tflag_d = 1'b0;
               busy_d  = 1'b1;
               start_d = 1'b1;
            end else if (ack) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         end

         S_STOP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, watchdog counter and output registers; everything freezes when ena=0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         start_cmd    <= 1'b0;
         stop_cmd     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
         result_out   <= '0;
      end else if (ena) begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_cmd    <= start_d;
         stop_cmd     <= stop_d;
         busy         <= busy_d;
         done         <= done_d;
         timeout_flag <= tflag_d;
         result_out   <= result_d;
      end
   end

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Scoreboard bench for rsa_cmd_ctrl: stimulus pushes expected start/stop/done
// events, a negedge monitor pops and compares them as the DUT raises outputs.
module tb_rsa_cmd_ctrl;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        go;
   logic        abort;
   logic        ack;
   logic [15:0] timeout_val;
   logic        eocp;
   logic        eoc;
   logic [7:0]  result_in;
   logic        start_cmd;
   logic        stop_cmd;
   logic        busy;
   logic        done;
   logic        timeout_flag;
   logic [7:0]  result_out;

   typedef struct {
      int         kind;   // 0 start, 1 stop, 2 done
      int         cyc;
      logic [7:0] res;
      logic       tflag;
      logic       dn;
      logic       bsy;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc;
   int         n_cmp;
   int         n_err;
   logic       p_start;
   logic       p_stop;
   logic       p_done;
   logic [7:0] exp_res;
   int         n_edge;
   int         m_edge;

   rsa_cmd_ctrl #(.WIDTH(8), .TIMEOUT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .ena          (ena),
      .go           (go),
      .abort        (abort),
      .ack          (ack),
      .timeout_val  (timeout_val),
      .eocp         (eocp),
      .eoc          (eoc),
      .result_in    (result_in),
      .start_cmd    (start_cmd),
      .stop_cmd     (stop_cmd),
      .busy         (busy),
      .done         (done),
      .timeout_flag (timeout_flag),
      .result_out   (result_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input int c, input logic [7:0] res,
                          input logic tf, input logic dn, input logic bsy);
      ev_t e;
      e.kind = kind; e.cyc = c; e.res = res; e.tflag = tf; e.dn = dn; e.bsy = bsy;
      exp_q.push_back(e);
   endtask

   task automatic handle(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("ev_kind",  32'(kind),         32'(e.kind));
         chk("ev_cycle", 32'(cyc),          32'(e.cyc));
         chk("ev_res",   32'(result_out),   32'(e.res));
         chk("ev_tflag", 32'(timeout_flag), 32'(e.tflag));
         chk("ev_done",  32'(done),         32'(e.dn));
         chk("ev_busy",  32'(busy),         32'(e.bsy));
      end
   endtask

   // Monitor: detect rising start_cmd / stop_cmd / done and score them.
   always @(negedge clk) begin
      if (!rst) begin
         if (start_cmd && !p_start) handle(0);
         if (stop_cmd  && !p_stop)  handle(1);
         if (done      && !p_done)  handle(2);
      end
      p_start = start_cmd;
      p_stop  = stop_cmd;
      p_done  = done;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive go for one edge; returns the edge number at which it is sampled.
   task automatic launch(output int edge_n);
      go = 1'b1;
      edge_n = cyc + 1;
      step(1);
      go = 1'b0;
   endtask

   // eocp at edge M, eoc with result at M+1; done expected after M+1.
   task automatic finish_run(input logic [7:0] res);
      eocp = 1'b1;
      m_edge = cyc + 1;
      push_ev(2, m_edge + 1, res, 1'b0, 1'b1, 1'b0);
      step(1);
      eocp = 1'b0;
      eoc = 1'b1;
      result_in = res;
      step(1);
      eoc = 1'b0;
      result_in = 8'h00;
      exp_res = res;
   endtask

   initial begin
      cyc = 0; n_cmp = 0; n_err = 0;
      p_start = 1'b0; p_stop = 1'b0; p_done = 1'b0;
      rst = 1'b1; ena = 1'b1; go = 1'b0; abort = 1'b0; ack = 1'b0;
      timeout_val = 16'd0; eocp = 1'b0; eoc = 1'b0; result_in = 8'h00;
      exp_res = 8'h00;

      // Reset state
      step(3);
      chk("rst_start_cmd", 32'(start_cmd), 0);
      chk("rst_stop_cmd",  32'(stop_cmd), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_done",      32'(done), 0);
      chk("rst_tflag",     32'(timeout_flag), 0);
      chk("rst_result",    32'(result_out), 0);
      rst = 1'b0;
      step(2);

      // Normal run, with an ignored go while busy
      timeout_val = 16'd100;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      chk("norm_start_hi", 32'(start_cmd), 1);
      step(1);
      chk("norm_start_lo", 32'(start_cmd), 0);
      step(4);
      go = 1'b1;
      step(1);
      go = 1'b0;
      step(4);
      finish_run(8'hA5);
      chk("norm_done",   32'(done), 1);
      chk("norm_busy",   32'(busy), 0);
      chk("norm_result", 32'(result_out), 32'h A5);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      chk("ack_done",   32'(done), 0);
      chk("ack_result", 32'(result_out), 32'h A5);
      step(2);

      // Watchdog expiry: stop_cmd at edge N+5 with timeout_flag
      timeout_val = 16'd5;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      push_ev(1, n_edge + 5, exp_res, 1'b1, 1'b0, 1'b1);
      launch(n_edge);
      step(10);
      chk("to_tflag",  32'(timeout_flag), 1);
      chk("to_done",   32'(done), 0);
      chk("to_busy",   32'(busy), 0);
      chk("to_stop",   32'(stop_cmd), 0);

      // Abort precedence over eocp in WAIT
      timeout_val = 16'd100;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      step(2);
      abort = 1'b1;
      eocp = 1'b1;
      push_ev(1, cyc + 1, exp_res, 1'b0, 1'b0, 1'b1);
      step(1);
      abort = 1'b0;
      eocp = 1'b0;
      eoc = 1'b1;
      result_in = 8'h3C;
      step(3);
      eoc = 1'b0;
      result_in = 8'h00;
      chk("ab_result", 32'(result_out), 32'h A5);
      chk("ab_done",   32'(done), 0);
      chk("ab_tflag",  32'(timeout_flag), 0);
      chk("ab_busy",   32'(busy), 0);

      // Watchdog disabled across a long conversion
      timeout_val = 16'd0;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      step(70000);
      finish_run(8'h5A);
      chk("dis_result", 32'(result_out), 32'h5A);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(1);

      // eocp on the counter==1 edge: capture wins over expiry
      timeout_val = 16'd3;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      step(2);
      chk("col_edge", 32'(cyc + 1), 32'(n_edge + 3));
      finish_run(8'h77);
      chk("col_tflag",  32'(timeout_flag), 0);
      chk("col_result", 32'(result_out), 32'h77);
      step(2);

      // go together with ack in DONE relaunches; go while busy is ignored
      timeout_val = 16'd100;
      ack = 1'b1;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      ack = 1'b0;
      chk("b2b_done", 32'(done), 0);
      chk("b2b_busy", 32'(busy), 1);
      step(3);
      go = 1'b1;
      step(1);
      go = 1'b0;
      step(3);
      finish_run(8'h11);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(1);

      // ena low for 4 edges in START: start_cmd held, watchdog frozen
      timeout_val = 16'd5;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      push_ev(1, n_edge + 9, exp_res, 1'b1, 1'b0, 1'b1);
      launch(n_edge);
      ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("ena_start_held", 32'(start_cmd), 1);
      end
      ena = 1'b1;
      step(12);
      chk("ena_busy", 32'(busy), 0);

      // Asynchronous reset mid-run in WAIT
      timeout_val = 16'd100;
      n_edge = cyc + 1;
      push_ev(0, n_edge, exp_res, 1'b0, 1'b0, 1'b1);
      launch(n_edge);
      step(3);
      #2 rst = 1'b1;
      #1;
      chk("ar_start_cmd", 32'(start_cmd), 0);
      chk("ar_stop_cmd",  32'(stop_cmd), 0);
      chk("ar_busy",      32'(busy), 0);
      chk("ar_done",      32'(done), 0);
      chk("ar_tflag",     32'(timeout_flag), 0);
      chk("ar_result",    32'(result_out), 0);
      step(1);
      rst = 1'b0;
      step(5);
      chk("ar_idle_busy", 32'(busy), 0);

      chk("pending_events", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
